dcache_controller: RTL

- Direct-mapped, write-back, write-allocate data cache and controller between the CPU load/store path and a slow word-wide data memory.
- Services byte reads and writes from the CPU.
- Stalls the CPU through BUSYWAIT on a miss.
- Sequences write-back and block fetch with main memory through a request/busywait handshake.

---
 rtl/dcache_controller_if.sv | 28 ++
 rtl/dcache_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side handshake bundle of the direct-mapped data cache.
// The cache binds to the slave modport; the CPU/memory environment binds to master.
interface dcache_controller_if #(
   parameter int ADDR_W = 8
);
   logic              READ;
   logic              WRITE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [7:0]        WRITEDATA;
   logic [7:0]        READDATA;
   logic              BUSYWAIT;
   logic              MEM_READ;
   logic              MEM_WRITE;
   logic [ADDR_W-3:0] MEM_ADDRESS;
   logic [31:0]       MEM_WRITEDATA;
   logic [31:0]       MEM_READDATA;
   logic              MEM_BUSYWAIT;

   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache with one 32-bit word per line.
// Misses stall the CPU while a dirty victim is written back and the new line is fetched.
module dcache_controller #(
   parameter int NUM_BLOCKS  = 8,
   parameter int BLOCK_BYTES = 4,
   parameter int ADDR_W      = 8
) (
   input  logic                CLK,
   input  logic                RESET,
   dcache_controller_if.slave  bus
);
   localparam int IW = $clog2(NUM_BLOCKS);
   localparam int OW = $clog2(BLOCK_BYTES);
   localparam int TW = ADDR_W - IW - OW;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] FETCH     = 2'd2;

   logic [31:0]           data_r  [NUM_BLOCKS];
   logic [TW-1:0]         tag_r   [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid_r;
   logic [NUM_BLOCKS-1:0] dirty_r;
   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;

   logic [TW-1:0] tag_s;
   logic [IW-1:0] idx_s;
   logic [OW-1:0] off_s;
   logic [31:0]   line_s;
   logic          hit_s;
   logic          req_s;
   logic          wr_hit_s;
   logic          wb_done_s;
   logic          fill_s;

   // Address split, hit detection and read-byte selection.
   always_comb begin
      tag_s    = bus.ADDRESS[ADDR_W-1 -: TW];
      idx_s    = bus.ADDRESS[IW+OW-1 : OW];
      off_s    = bus.ADDRESS[OW-1:0];
      line_s   = data_r[idx_s];
      hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
      req_s    = bus.READ | bus.WRITE;
      wr_hit_s = (state_r == IDLE) && bus.WRITE && hit_s;
      case (off_s)
         2'd0:    bus.READDATA = line_s[7:0];
         2'd1:    bus.READDATA = line_s[15:8];
         2'd2:    bus.READDATA = line_s[23:16];
         2'd3:    bus.READDATA = line_s[31:24];
         default: bus.READDATA = 8'h00;
      endcase
   end

   // CPU stall and memory request outputs; everything is forced quiet while RESET is high.
   always_comb begin
      bus.BUSYWAIT      = 1'b0;
      bus.MEM_READ      = 1'b0;
      bus.MEM_WRITE     = 1'b0;
      bus.MEM_ADDRESS   = {(ADDR_W-2){1'b0}};
      bus.MEM_WRITEDATA = 32'h0000_0000;
      if (RESET) begin
         bus.BUSYWAIT = 1'b0;
      end else begin
         bus.BUSYWAIT = req_s && !((state_r == IDLE) && hit_s);
         case (state_r)
            WRITEBACK: begin
               bus.MEM_WRITE     = 1'b1;
               bus.MEM_ADDRESS   = {tag_r[idx_s], idx_s};
               bus.MEM_WRITEDATA = line_s;
            end
            FETCH: begin
               bus.MEM_READ    = 1'b1;
               bus.MEM_ADDRESS = {tag_s, idx_s};
            end
            default: begin
               bus.MEM_READ  = 1'b0;
               bus.MEM_WRITE = 1'b0;
            end
         endcase
      end
   end

   // Miss sequencing: a dirty victim goes out before the new line comes in.
   always_comb begin
      state_nxt_s = state_r;
      wb_done_s   = (state_r == WRITEBACK) && !bus.MEM_BUSYWAIT;
      fill_s      = (state_r == FETCH) && !bus.MEM_BUSYWAIT;
      case (state_r)
         IDLE: begin
            if (req_s && !hit_s) begin
               if (valid_r[idx_s] && dirty_r[idx_s]) begin
                  state_nxt_s = WRITEBACK;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WRITEBACK: begin
            if (wb_done_s) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = WRITEBACK;
            end
         end
         FETCH: begin
            if (fill_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state and per-line valid/dirty flags.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= IDLE;
         valid_r <= {NUM_BLOCKS{1'b0}};
         dirty_r <= {NUM_BLOCKS{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (wr_hit_s) begin
            dirty_r[idx_s] <= 1'b1;
         end else if (wb_done_s) begin
            dirty_r[idx_s] <= 1'b0;
         end else if (fill_s) begin
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
         end
      end
   end

   // Line data and tags keep their contents across reset; only the flags are cleared.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (fill_s) begin
            data_r[idx_s] <= bus.MEM_READDATA;
            tag_r[idx_s]  <= tag_s;
         end else if (wr_hit_s) begin
            data_r[idx_s][{off_s, 3'b000} +: 8] <= bus.WRITEDATA;
         end
      end
   end
endmodule
